// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_sequencer
// Description : Four-phase (Q1..Q4) execute sequencer for the PIC16C57 8-bit
//               ALU. Accepts one ALU-class instruction and decodes it. Reads the
//               file-register operand and drives the external ALU for one
//               phase. Writes the result back to W or to the file register.
//               Owns the W register and the STATUS flags {Z,DC,C}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 12,
    parameter int ADDR_WIDTH = 5,
    parameter int FUNC_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] instIn,
    input  logic                  instValid,
    output logic                  instReady,
    output logic [ADDR_WIDTH-1:0] fAddrOut,
    input  logic [DATA_WIDTH-1:0] fDataIn,
    output logic                  fWe,
    output logic [DATA_WIDTH-1:0] fDataOut,
    output logic [FUNC_WIDTH-1:0] aluFuncOut,
    output logic [DATA_WIDTH-1:0] aluWOut,
    output logic [DATA_WIDTH-1:0] aluFOut,
    output logic [DATA_WIDTH-1:0] aluLitOut,
    output logic [2:0]            aluBitSelOut,
    output logic                  aluCFlagOut,
    input  logic [DATA_WIDTH-1:0] aluResultIn,
    input  logic [2:0]            aluStatusIn,
    output logic [DATA_WIDTH-1:0] wRegOut,
    output logic [2:0]            statusOut,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    // ALU function codes shared with the ALU datapath; zero means "no operation"
    localparam logic [FUNC_WIDTH-1:0] c_ALU__IDLE = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_ADD   = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_SUB   = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_AND   = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_COM   = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_DEC   = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_INC   = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_IOR   = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_RLF   = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_RRF   = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_SWAP  = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_XOR   = FUNC_WIDTH'(11);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_BCF   = FUNC_WIDTH'(12);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_BSF   = FUNC_WIDTH'(13);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_ANDL  = FUNC_WIDTH'(14);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_IORL  = FUNC_WIDTH'(15);
    localparam logic [FUNC_WIDTH-1:0] c_ALU_XORL  = FUNC_WIDTH'(16);

    // STATUS update masks, bit order {Z,DC,C}
    localparam logic [2:0] c_MASK_ALL  = 3'b111;
    localparam logic [2:0] c_MASK_C    = 3'b001;
    localparam logic [2:0] c_MASK_Z    = 3'b100;
    localparam logic [2:0] c_MASK_NONE = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_Q1   = 3'd1,
        S_Q2   = 3'd2,
        S_Q3   = 3'd3,
        S_Q4   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [INST_WIDTH-1:0]   r_inst;
    logic [FUNC_WIDTH-1:0]   r_func;
    logic                    r_destF;
    logic [2:0]              r_mask;
    logic [DATA_WIDTH-1:0]   r_fLatch;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [2:0]              r_aluStatus;
    logic [DATA_WIDTH-1:0]   r_w;
    logic [2:0]              r_status;

    logic [FUNC_WIDTH-1:0]   w_decFunc;
    logic                    w_decDestF;
    logic [2:0]              w_decMask;
    logic                    w_decLegal;
    logic                    w_accept;

    assign w_accept = instValid & instReady;

    // Decode the latched instruction into ALU function, destination and flag mask
    always_comb begin
        w_decFunc  = c_ALU__IDLE;
        w_decDestF = 1'b0;
        w_decMask  = c_MASK_NONE;
        w_decLegal = 1'b1;
        casez (r_inst[11:6])
            6'b000111: begin w_decFunc = c_ALU_ADD;  w_decDestF = r_inst[5]; w_decMask = c_MASK_ALL;  end
            6'b000010: begin w_decFunc = c_ALU_SUB;  w_decDestF = r_inst[5]; w_decMask = c_MASK_ALL;  end
            6'b000101: begin w_decFunc = c_ALU_AND;  w_decDestF = r_inst[5]; w_decMask = c_MASK_Z;    end
            6'b001001: begin w_decFunc = c_ALU_COM;  w_decDestF = r_inst[5]; w_decMask = c_MASK_Z;    end
            6'b000011: begin w_decFunc = c_ALU_DEC;  w_decDestF = r_inst[5]; w_decMask = c_MASK_Z;    end
            6'b001010: begin w_decFunc = c_ALU_INC;  w_decDestF = r_inst[5]; w_decMask = c_MASK_Z;    end
            6'b000100: begin w_decFunc = c_ALU_IOR;  w_decDestF = r_inst[5]; w_decMask = c_MASK_Z;    end
            6'b001101: begin w_decFunc = c_ALU_RLF;  w_decDestF = r_inst[5]; w_decMask = c_MASK_C;    end
            6'b001100: begin w_decFunc = c_ALU_RRF;  w_decDestF = r_inst[5]; w_decMask = c_MASK_C;    end
            6'b001110: begin w_decFunc = c_ALU_SWAP; w_decDestF = r_inst[5]; w_decMask = c_MASK_NONE; end
            6'b000110: begin w_decFunc = c_ALU_XOR;  w_decDestF = r_inst[5]; w_decMask = c_MASK_Z;    end
            // bit ops always write back to the file register
            6'b0100??: begin w_decFunc = c_ALU_BCF;  w_decDestF = 1'b1;      w_decMask = c_MASK_NONE; end
            6'b0101??: begin w_decFunc = c_ALU_BSF;  w_decDestF = 1'b1;      w_decMask = c_MASK_NONE; end
            // literal ops always write back to W
            6'b1110??: begin w_decFunc = c_ALU_ANDL; w_decDestF = 1'b0;      w_decMask = c_MASK_Z;    end
            6'b1101??: begin w_decFunc = c_ALU_IORL; w_decDestF = 1'b0;      w_decMask = c_MASK_Z;    end
            6'b1111??: begin w_decFunc = c_ALU_XORL; w_decDestF = 1'b0;      w_decMask = c_MASK_Z;    end
            default:   w_decLegal = 1'b0;
        endcase
    end

    // Phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next phase and per-phase control outputs
    always_comb begin
        w_nextState = r_state;
        instReady   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        fWe         = 1'b0;
        aluFuncOut  = c_ALU__IDLE;
        case (r_state)
            S_IDLE: begin
                instReady = 1'b1;
                if (instValid) begin
                    w_nextState = S_Q1;
                end
            end
            S_Q1: begin
                busy = 1'b1;
                if (w_decLegal) begin
                    w_nextState = S_Q2;
                end else begin
                    illegal     = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_Q2: begin
                busy        = 1'b1;
                w_nextState = S_Q3;
            end
            S_Q3: begin
                busy        = 1'b1;
                aluFuncOut  = r_func;
                w_nextState = S_Q4;
            end
            S_Q4: begin
                busy        = 1'b1;
                done        = 1'b1;
                instReady   = 1'b1;
                fWe         = r_destF;
                w_nextState = instValid ? S_Q1 : S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath registers: instruction latch, decode, operand, result, W and STATUS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst      <= '0;
            r_func      <= c_ALU__IDLE;
            r_destF     <= 1'b0;
            r_mask      <= c_MASK_NONE;
            r_fLatch    <= '0;
            r_result    <= '0;
            r_aluStatus <= 3'b000;
            r_w         <= '0;
            r_status    <= 3'b000;
        end else begin
            if (w_accept) begin
                r_inst <= instIn;
            end
            if (r_state == S_Q1) begin
                r_func  <= w_decFunc;
                r_destF <= w_decDestF;
                r_mask  <= w_decMask;
            end
            if (r_state == S_Q2) begin
                r_fLatch <= fDataIn;
            end
            if (r_state == S_Q3) begin
                r_result    <= aluResultIn;
                r_aluStatus <= aluStatusIn;
            end
            if (r_state == S_Q4) begin
                if (!r_destF) begin
                    r_w <= r_result;
                end
                r_status <= (r_status & ~r_mask) | (r_aluStatus & r_mask);
            end
        end
    end

    assign fAddrOut     = r_inst[ADDR_WIDTH-1:0];
    assign fDataOut     = r_result;
    assign aluWOut      = r_w;
    assign aluFOut      = r_fLatch;
    assign aluLitOut    = r_inst[DATA_WIDTH-1:0];
    assign aluBitSelOut = r_inst[7:5];
    assign aluCFlagOut  = r_status[0];
    assign wRegOut      = r_w;
    assign statusOut    = r_status;

endmodule
`default_nettype wire
